// File: rtl/text_buf_pkg.sv
// Shared constants and types for the character text buffer writer.
//   ROWS/COLS     : buffer geometry (powers of two)
//   ROW_W/COL_W   : address widths derived from the geometry
//   DATA_W        : character width
//   ASCII_*       : control and range-limit byte values
//   state_e       : writer FSM state encoding
package text_buf_pkg;

  localparam int unsigned ROWS   = 32;
  localparam int unsigned COLS   = 4;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = ROW_W + COL_W;

  localparam logic [DATA_W-1:0] ASCII_CR  = 8'h0D;
  localparam logic [DATA_W-1:0] ASCII_LF  = 8'h0A;
  localparam logic [DATA_W-1:0] ASCII_BS  = 8'h08;
  localparam logic [DATA_W-1:0] ASCII_FF  = 8'h0C;
  localparam logic [DATA_W-1:0] ASCII_SP  = 8'h20;
  localparam logic [DATA_W-1:0] ASCII_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/text_cursor.sv
// Text cursor: row/column position counter with wrap-around.
//   clk, reset       : clock, synchronous active-high reset
//   advance_i        : step one cell forward (col fastest, full wrap to top)
//   retreat_i        : step one cell back
//   cr_i             : column to 0
//   lf_i             : row + 1 (wrap), column unchanged
//   zero_i           : cursor to (0,0); overrides all other controls
//   row_o/col_o      : current cursor position
//   prev_row_o/col_o : position one cell back (the BS target cell)
//   at_origin_o      : cursor is at (0,0)
module text_cursor
  import text_buf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             retreat_i,
  input  logic             cr_i,
  input  logic             lf_i,
  input  logic             zero_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] prev_row_o,
  output logic [COL_W-1:0] prev_col_o,
  output logic             at_origin_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] next_row;
  logic [COL_W-1:0] next_col;
  logic [ROW_W-1:0] prev_row;
  logic [COL_W-1:0] prev_col;

  // Power-of-two geometry: plain +/-1 gives the modulo wrap for free.
  always_comb begin
    next_col = col_q + 1'b1;
    next_row = (col_q == '1) ? row_q + 1'b1 : row_q;
    prev_col = col_q - 1'b1;
    prev_row = (col_q == '0) ? row_q - 1'b1 : row_q;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (zero_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      row_d = next_row;
      col_d = next_col;
    end else if (retreat_i) begin
      row_d = prev_row;
      col_d = prev_col;
    end else if (cr_i) begin
      col_d = '0;
    end else if (lf_i) begin
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o       = row_q;
  assign col_o       = col_q;
  assign prev_row_o  = prev_row;
  assign prev_col_o  = prev_col;
  assign at_origin_o = (row_q == '0) && (col_q == '0);

endmodule

// File: rtl/text_buffer_writer.sv
// Writer side of the character text buffer. Accepts bytes over valid/ready,
// interprets CR/LF/BS/FF, owns the cursor and drives the RAM write port.
// A clear (clear_req or FF) sweeps every cell with 0x00, one per clock.
//   clk, reset          : clock, synchronous active-high reset
//   rx_data/valid/ready : incoming byte handshake
//   clear_req           : one-cycle request to clear the buffer
//   we/w_row/w_col/din  : registered RAM write port
//   cur_row/cur_col     : cursor position for display
//   busy                : clear sweep in progress
module text_buffer_writer
  import text_buf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              clear_req,
  output logic              we,
  output logic [ROW_W-1:0]  w_row,
  output logic [COL_W-1:0]  w_col,
  output logic [DATA_W-1:0] din,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic              busy
);

  state_e            state_q;
  logic              we_q;
  logic [ROW_W-1:0]  w_row_q;
  logic [COL_W-1:0]  w_col_q;
  logic [DATA_W-1:0] din_q;
  logic              busy_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_next;

  logic              accept;
  logic              is_print;
  logic              start_clear;
  logic              do_adv;
  logic              do_bs;
  logic              do_cr;
  logic              do_lf;
  logic              sweep_done;
  logic [ROW_W-1:0]  crow;
  logic [COL_W-1:0]  ccol;
  logic [ROW_W-1:0]  prow;
  logic [COL_W-1:0]  pcol;
  logic              at_origin;

  assign rx_ready = (state_q == ST_IDLE) && !clear_req;
  assign accept   = rx_valid && rx_ready;
  assign is_print = (rx_data >= ASCII_SP) && (rx_data < ASCII_DEL);

  always_comb begin
    start_clear = (state_q == ST_IDLE) &&
                  (clear_req || (accept && rx_data == ASCII_FF));
    do_adv      = accept && is_print;
    do_bs       = accept && (rx_data == ASCII_BS) && !at_origin;
    do_cr       = accept && (rx_data == ASCII_CR);
    do_lf       = accept && (rx_data == ASCII_LF);
    sweep_done  = (state_q == ST_CLEAR) && (idx_q == '1);
    idx_next    = idx_q + 1'b1;
  end

  text_cursor u_cursor (
    .clk         (clk),
    .reset       (reset),
    .advance_i   (do_adv),
    .retreat_i   (do_bs),
    .cr_i        (do_cr),
    .lf_i        (do_lf),
    .zero_i      (sweep_done),
    .row_o       (crow),
    .col_o       (ccol),
    .prev_row_o  (prow),
    .prev_col_o  (pcol),
    .at_origin_o (at_origin)
  );

  // idx_q names the cell whose write is on the port this cycle, so the
  // (0,0) write is launched on the same edge that enters CLEAR and busy/we
  // stay aligned for exactly ROWS*COLS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      w_row_q <= '0;
      w_col_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q <= 1'b0;
          if (start_clear) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            we_q    <= 1'b1;
            w_row_q <= '0;
            w_col_q <= '0;
            din_q   <= '0;
          end else if (do_adv) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            w_row_q <= crow;
            w_col_q <= ccol;
            din_q   <= rx_data;
          end else if (do_bs) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            w_row_q <= prow;
            w_col_q <= pcol;
            din_q   <= '0;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
        end
        ST_CLEAR: begin
          if (sweep_done) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            idx_q   <= idx_next;
            we_q    <= 1'b1;
            w_row_q <= idx_next[IDX_W-1 -: ROW_W];
            w_col_q <= idx_next[COL_W-1:0];
            din_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign we      = we_q;
  assign w_row   = w_row_q;
  assign w_col   = w_col_q;
  assign din     = din_q;
  assign busy    = busy_q;
  assign cur_row = crow;
  assign cur_col = ccol;

endmodule
